dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 71 +++++++
 tb/tb_dmem_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: core/DMA arbiter for one single-port data memory (c_* core port, d_* DMA burst port, m_* memory port)
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wd,
  output logic              c_gnt,
  output logic              c_stall,
  output logic [DATA_W-1:0] c_rd,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_len,
  input  logic [DATA_W-1:0] d_wd,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rd,
  output logic              d_done,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wd,
  input  logic [DATA_W-1:0] m_rd
);
  typedef enum logic [1:0] {IDLE, CORE, DMA} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] cur_addr;
  logic [3:0] remaining;
  logic dir;
  logic core_xfer, dma_beat, last, enter_dma;
  assign c_gnt = state == CORE;
  assign d_gnt = state == DMA;
  assign c_stall = c_req & ~c_gnt;
  assign core_xfer = c_gnt & c_req;
  assign dma_beat = d_gnt & d_req;
  assign last = dma_beat & (remaining == 4'd0);
  assign d_done = last;
  always_comb begin
    state_nx = state == IDLE ? (c_req ? CORE : d_req ? DMA : IDLE)
             : state == CORE ? (d_req ? DMA : CORE)
             : state == DMA  ? (!last ? DMA : c_req ? CORE : d_req ? DMA : IDLE)
             : IDLE;
    enter_dma = state_nx == DMA && (state != DMA || last);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cur_addr <= '0;
      remaining <= '0;
      dir <= 1'b0;
    end else begin
      state <= state_nx;
      if (enter_dma) begin
        cur_addr <= d_addr;
        remaining <= d_len;
        dir <= d_we;
      end else if (dma_beat) begin
        cur_addr <= cur_addr + ADDR_W'(4);
        remaining <= remaining - 4'd1;
      end
    end
  end
  assign m_we = core_xfer ? c_we : dma_beat & dir;
  assign m_addr = core_xfer ? c_addr : dma_beat ? cur_addr : '0;
  assign m_wd = core_xfer ? c_wd : dma_beat ? d_wd : '0;
  assign c_rd = core_xfer ? m_rd : '0;
  assign d_rd = dma_beat ? m_rd : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized scoreboard bench for dmem_arbiter against a queue-based ownership model
module tb_dmem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wd, d_addr, d_wd;
  logic [3:0] d_len;
  logic c_gnt, c_stall, d_gnt, d_done, m_we;
  logic [31:0] c_rd, d_rd, m_addr, m_wd, m_rd;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  assign m_rd = mem[m_addr[9:2]];
  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wd(c_wd),
    .c_gnt(c_gnt), .c_stall(c_stall), .c_rd(c_rd),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_len(d_len), .d_wd(d_wd),
    .d_gnt(d_gnt), .d_rd(d_rd), .d_done(d_done),
    .m_we(m_we), .m_addr(m_addr), .m_wd(m_wd), .m_rd(m_rd)
  );
  typedef struct {
    logic src;
    logic we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic done;
  } xfer_t;
  typedef struct {
    logic chk;
    logic cg;
    logic dg;
    logic stall;
    logic done;
  } stat_t;
  xfer_t xq[$];
  stat_t sq[$];
  int cmp = 0;
  int bad = 0;
  int owner = 0;
  logic [31:0] bq[$];
  logic bdir = 1'b0;
  logic m_cx = 1'b0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic start_burst();
    bq.delete();
    for (int i = 0; i <= int'(d_len); i++) bq.push_back(d_addr + 32'(4 * i));
    bdir = d_we;
    owner = 2;
  endtask
  task automatic step(bit chk_on = 1'b1);
    bit cg, dg, cx, dx, last;
    xfer_t x;
    stat_t s;
    cg = owner == 1;
    dg = owner == 2;
    cx = cg && c_req;
    dx = dg && d_req;
    last = dx && bq.size() == 1;
    m_cx = cx;
    x = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0};
    if (cx) x = '{1'b0, c_we, c_addr, c_wd, 32'h0, 1'b0};
    else if (dx) x = '{1'b1, bdir, bq[0], d_wd, 32'h0, last};
    if (cx || dx) begin
      x.rd = ref_mem[x.addr[9:2]];
      if (x.we) ref_mem[x.addr[9:2]] = x.wd;
      xq.push_back(x);
    end
    s = '{chk_on, cg, dg, c_req && !cg, last};
    sq.push_back(s);
    if (dx) void'(bq.pop_front());
    if (rst) begin
      owner = 0;
      bq.delete();
    end else if (owner == 0) begin
      if (c_req) owner = 1;
      else if (d_req) start_burst();
    end else if (owner == 1) begin
      if (d_req) start_burst();
    end else if (last) begin
      if (c_req) owner = 1;
      else if (d_req) start_burst();
      else owner = 0;
    end
    #3;
    if (m_we) mem[m_addr[9:2]] = m_wd;
    @(negedge clk);
  endtask
  initial begin
    stat_t s;
    xfer_t x;
    forever begin
      @(negedge clk);
      #2;
      if (sq.size() != 0) begin
        s = sq.pop_front();
        if (s.chk) begin
          chk("c_gnt", 32'(c_gnt), 32'(s.cg));
          chk("d_gnt", 32'(d_gnt), 32'(s.dg));
          chk("c_stall", 32'(c_stall), 32'(s.stall));
          chk("d_done", 32'(d_done), 32'(s.done));
          if ((c_gnt && c_req) || (d_gnt && d_req)) begin
            if (xq.size() == 0) begin
              cmp++;
              bad++;
              $display("FAIL xfer: unexpected transfer at addr %h, none required", m_addr);
            end else begin
              x = xq.pop_front();
              chk("m_we", 32'(m_we), 32'(x.we));
              chk("m_addr", m_addr, x.addr);
              chk("m_wd", m_wd, x.wd);
              chk(x.src ? "d_rd" : "c_rd", x.src ? d_rd : c_rd, x.rd);
              chk(x.src ? "c_rd_idle" : "d_rd_idle", x.src ? c_rd : d_rd, 32'h0);
            end
          end else begin
            chk("idle_m_we", 32'(m_we), 32'h0);
            chk("idle_m_addr", m_addr, 32'h0);
            chk("idle_m_wd", m_wd, 32'h0);
            chk("idle_c_rd", c_rd, 32'h0);
            chk("idle_d_rd", d_rd, 32'h0);
          end
        end
      end
    end
  end
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    rst = 1'b1; c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wd = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_len = '0; d_wd = '0;
    @(negedge clk);
    step(1'b0);
    step();
    rst = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      c_addr = 32'h20 + 32'(4 * i);
      step();
    end
    c_addr = 32'h40; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_len = 4'd3;
    for (int i = 0; i < 5; i++) begin
      d_wd = $urandom;
      step();
    end
    d_req = 1'b0;
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_len = 4'd2;
    step();
    step();
    d_req = 1'b0;
    step();
    step();
    d_req = 1'b1;
    step();
    step();
    d_req = 1'b0;
    step();
    c_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 32'hFFFF_FFFC; d_len = 4'd1;
    d_wd = 32'hCAFE_0001;
    step();
    step();
    d_wd = 32'hCAFE_0002;
    step();
    d_req = 1'b0;
    step();
    step();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_len = 4'd3;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; d_req = 1'b0;
    step();
    step();
    for (int n = 0; n < 3000; n++) begin
      rst = $urandom_range(0, 199) == 0;
      if (!c_req || m_cx) begin
        c_req = $urandom_range(0, 9) < 4;
        c_we = 1'($urandom);
        c_addr = $urandom & 32'h3FC;
        c_wd = $urandom;
      end
      d_req = $urandom_range(0, 9) < 6;
      d_we = 1'($urandom);
      d_addr = $urandom_range(0, 7) == 0 ? 32'hFFFF_FFF0 : ($urandom & 32'h3FC);
      d_len = 4'($urandom);
      d_wd = $urandom;
      step();
    end
    rst = 1'b0; c_req = 1'b0; d_req = 1'b0;
    step();
    step();
    #5;
    chk("xq_drain", 32'(xq.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
